// File: rtl/pixel_stream_pkg.sv
// pixel_stream_pkg
//   Shared types and helpers for the Port V pixel stream tracker.
//   - tracker_state_t : IDLE / STREAM / CATCHUP state encoding
//   - calc_frame      : pixels per frame for a given resolution
//   - calc_pix_w      : width of a pixel index within one frame
//   - sat_inc         : saturating increment for counters up to 32 bits
package pixel_stream_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STREAM  = 2'd1,
    CATCHUP = 2'd2
  } tracker_state_t;

  function automatic int calc_frame(input int h_res, input int v_res);
    return h_res * v_res;
  endfunction

  // A one-pixel frame still needs a one-bit index.
  function automatic int calc_pix_w(input int frame);
    return (frame <= 1) ? 1 : $clog2(frame);
  endfunction

  // Returns value+1 unless value is already the largest number that fits
  // in 'width' bits, in which case it holds.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [32:0] max_val;
    max_val = (33'd1 << width) - 33'd1;
    if ({1'b0, value} >= max_val) begin
      return value;
    end
    return value + 32'd1;
  endfunction

endpackage

// File: rtl/pixel_stream_tracker_sat_counter.sv
// sat_counter
//   Statistics counter that increments on 'inc' and sticks at its
//   all-ones value instead of wrapping.
//   Ports:
//     clk   - system clock
//     rst_n - asynchronous active-low reset, clears the count
//     inc   - increment request for this cycle
//     count - current saturating count
module sat_counter
  import pixel_stream_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= WIDTH'(sat_inc(32'(count), WIDTH));
    end
  end

endmodule

// File: rtl/pixel_stream_tracker.sv
// pixel_stream_tracker
//   Sits between the SDRAM read-data return path and the Port V output
//   FIFO. Each cycle it decides whether returned read data is written as a
//   real pixel, whether a null pixel is written instead, or whether nothing
//   is written. An expected-pixel pointer tracks the next pixel the VGA side
//   needs; it wraps at frame size and is reloaded on frame_start.
//   Ports:
//     clk            - system clock
//     portV_arst_n   - asynchronous active-low reset
//     readValid      - raddr/rdata valid this cycle
//     raddr          - word address of the returned read data
//     readOffset     - frame-buffer base address
//     fifo_usedw     - output FIFO fill level
//     fifo_full      - output FIFO full
//     frame_start    - one-cycle pulse when the VGA reaches pixel (0,0)
//     wrreq          - write to the output FIFO (combinational)
//     nullData       - the write carries null data (only meaningful with wrreq)
//     state          - 0 IDLE, 1 STREAM, 2 CATCHUP
//     null_count     - null writes issued, saturating
//     drop_count     - valid reads discarded, saturating
//     overflow_count - matching reads lost to fifo_full, saturating
module pixel_stream_tracker
  import pixel_stream_pkg::*;
#(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int ADDR_W      = 25,
  parameter int USEDW_W     = 9,
  parameter int LOW_WATER   = 2,
  parameter int CATCHUP_MAX = 255,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               portV_arst_n,
  input  logic               readValid,
  input  logic [ADDR_W-1:0]  raddr,
  input  logic [ADDR_W-1:0]  readOffset,
  input  logic [USEDW_W-1:0] fifo_usedw,
  input  logic               fifo_full,
  input  logic               frame_start,
  output logic               wrreq,
  output logic               nullData,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   null_count,
  output logic [CNT_W-1:0]   drop_count,
  output logic [CNT_W-1:0]   overflow_count
);

  localparam int FRAME = calc_frame(H_RES, V_RES);
  localparam int PIX_W = calc_pix_w(FRAME);
  localparam int CU_W  = (CATCHUP_MAX < 1) ? 1 : $clog2(CATCHUP_MAX + 1);

  tracker_state_t state_q, state_d;
  logic [PIX_W-1:0]  exp_pix, exp_d, exp_next, exp_start;
  logic [CU_W-1:0]   catchup, catchup_d;
  logic [ADDR_W-1:0] rel, exp_ext, fwd;
  logic              match, in_frame, jump_ok, low_water;
  logic              wr, nul;
  logic              inc_null, inc_drop, inc_ovf;

  // Address arithmetic: offset into the frame buffer, and how far ahead
  // of the expected pixel that offset lies (modulo the frame).
  always_comb begin
    rel       = raddr - readOffset;
    exp_ext   = ADDR_W'(exp_pix);
    match     = readValid && (rel == exp_ext);
    in_frame  = rel < ADDR_W'(FRAME);
    if (rel >= exp_ext) begin
      fwd = rel - exp_ext;
    end else begin
      fwd = rel + ADDR_W'(FRAME) - exp_ext;
    end
    jump_ok   = in_frame && (fwd != '0) && (fwd <= ADDR_W'(CATCHUP_MAX));
    low_water = 32'(fifo_usedw) < 32'(LOW_WATER);
    exp_next  = (exp_pix == PIX_W'(FRAME - 1)) ? '0 : exp_pix + PIX_W'(1);
    exp_start = PIX_W'(32'(fifo_usedw) % 32'(FRAME));
  end

  // Write decision and next-state logic. Branch order is the priority:
  // a full FIFO blocks everything, then a matching read, then null fill,
  // then the STREAM-only choice between jumping ahead and dropping.
  always_comb begin
    wr        = 1'b0;
    nul       = 1'b0;
    inc_null  = 1'b0;
    inc_drop  = 1'b0;
    inc_ovf   = 1'b0;
    state_d   = state_q;
    exp_d     = exp_pix;
    catchup_d = catchup;

    if (fifo_full) begin
      inc_ovf = match;
    end else if (match && (state_q != IDLE)) begin
      wr        = 1'b1;
      exp_d     = exp_next;
      catchup_d = '0;
      state_d   = STREAM;
    end else if (low_water || (state_q == CATCHUP)) begin
      wr       = 1'b1;
      nul      = 1'b1;
      exp_d    = exp_next;
      inc_null = 1'b1;
      if (state_q == CATCHUP) begin
        if (catchup != '0) begin
          catchup_d = catchup - CU_W'(1);
        end
        if (catchup <= CU_W'(1)) begin
          state_d = STREAM;
        end
      end
    end else if ((state_q == STREAM) && readValid) begin
      if (jump_ok) begin
        catchup_d = CU_W'(fwd);
        state_d   = CATCHUP;
      end else begin
        inc_drop = 1'b1;
      end
    end

    // In IDLE every returned read is discarded, even during a null write.
    if (!fifo_full && readValid && (state_q == IDLE)) begin
      inc_drop = 1'b1;
    end

    // Frame start resynchronises the pointer but leaves the write alone.
    if (frame_start) begin
      state_d   = STREAM;
      exp_d     = exp_start;
      catchup_d = '0;
    end
  end

  always_ff @(posedge clk or negedge portV_arst_n) begin
    if (!portV_arst_n) begin
      state_q <= IDLE;
      exp_pix <= '0;
      catchup <= '0;
    end else begin
      state_q <= state_d;
      exp_pix <= exp_d;
      catchup <= catchup_d;
    end
  end

  // The write strobes are combinational, so reset must mask them directly.
  assign wrreq    = wr && portV_arst_n;
  assign nullData = nul && portV_arst_n;
  assign state    = state_q;

  sat_counter #(.WIDTH(CNT_W)) u_null_cnt (
    .clk   (clk),
    .rst_n (portV_arst_n),
    .inc   (inc_null),
    .count (null_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst_n (portV_arst_n),
    .inc   (inc_drop),
    .count (drop_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_ovf_cnt (
    .clk   (clk),
    .rst_n (portV_arst_n),
    .inc   (inc_ovf),
    .count (overflow_count)
  );

endmodule

// File: tb/tb_pixel_stream_tracker.sv
// tb_pixel_stream_tracker
//   Directed bench for pixel_stream_tracker. A small 10x5 frame (50 pixels)
//   keeps the wrap point reachable, CATCHUP_MAX=20 makes "too far ahead"
//   reachable inside one frame, and 4-bit counters make saturation cheap.
module tb_pixel_stream_tracker;

  localparam int ADDR_W  = 25;
  localparam int USEDW_W = 9;
  localparam int CNT_W   = 4;
  localparam logic [ADDR_W-1:0] OFFSET = 25'h0123456;

  logic               clk;
  logic               portV_arst_n;
  logic               readValid;
  logic [ADDR_W-1:0]  raddr;
  logic [ADDR_W-1:0]  readOffset;
  logic [USEDW_W-1:0] fifo_usedw;
  logic               fifo_full;
  logic               frame_start;
  logic               wrreq;
  logic               nullData;
  logic [1:0]         state;
  logic [CNT_W-1:0]   null_count;
  logic [CNT_W-1:0]   drop_count;
  logic [CNT_W-1:0]   overflow_count;

  int check_count = 0;
  int pass_count  = 0;

  pixel_stream_tracker #(
    .H_RES       (10),
    .V_RES       (5),
    .ADDR_W      (ADDR_W),
    .USEDW_W     (USEDW_W),
    .LOW_WATER   (2),
    .CATCHUP_MAX (20),
    .CNT_W       (CNT_W)
  ) dut (
    .clk            (clk),
    .portV_arst_n   (portV_arst_n),
    .readValid      (readValid),
    .raddr          (raddr),
    .readOffset     (readOffset),
    .fifo_usedw     (fifo_usedw),
    .fifo_full      (fifo_full),
    .frame_start    (frame_start),
    .wrreq          (wrreq),
    .nullData       (nullData),
    .state          (state),
    .null_count     (null_count),
    .drop_count     (drop_count),
    .overflow_count (overflow_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  // Drive inputs just after a rising edge, then wait to the falling edge
  // so the combinational write strobes have settled.
  task automatic apply_stimulus(input logic rv, input int rel_v, input int usedw,
                                input logic full, input logic fs);
    readValid   = rv;
    raddr       = OFFSET + ADDR_W'(rel_v);
    fifo_usedw  = USEDW_W'(usedw);
    fifo_full   = full;
    frame_start = fs;
    @(negedge clk);
  endtask

  // One cycle: stimulus, write-strobe check, clock edge, state check.
  task automatic step(input string tag, input logic rv, input int rel_v, input int usedw,
                      input logic full, input logic fs, input logic exp_wr,
                      input logic exp_null, input int exp_state);
    apply_stimulus(rv, rel_v, usedw, full, fs);
    check_output({tag, "_wrreq"}, 32'(wrreq), 32'(exp_wr));
    if (exp_wr) begin
      check_output({tag, "_nullData"}, 32'(nullData), 32'(exp_null));
    end
    @(posedge clk);
    #1;
    check_output({tag, "_state"}, 32'(state), 32'(exp_state));
  endtask

  initial begin
    portV_arst_n = 1'b0;
    readOffset   = OFFSET;
    readValid    = 1'b0;
    raddr        = OFFSET;
    fifo_usedw   = '0;
    fifo_full    = 1'b0;
    frame_start  = 1'b0;

    // Reset with usedw=0: low water would request a null write if not masked.
    apply_stimulus(1'b0, 0, 0, 1'b0, 1'b0);
    check_output("rst_wrreq", 32'(wrreq), 32'd0);
    check_output("rst_nullData", 32'(nullData), 32'd0);
    check_output("rst_state", 32'(state), 32'd0);
    check_output("rst_null_count", 32'(null_count), 32'd0);
    check_output("rst_drop_count", 32'(drop_count), 32'd0);
    check_output("rst_overflow_count", 32'(overflow_count), 32'd0);
    @(posedge clk);
    #1;
    portV_arst_n = 1'b1;

    // IDLE at low water: a null write every cycle, pointer 0 -> 3.
    for (int i = 0; i < 3; i++) begin
      step("idle_null", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    end
    check_output("idle_null_count", 32'(null_count), 32'd3);

    // IDLE ignores even a matching read, counting it as dropped.
    step("idle_read", 1'b1, 3, 5, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check_output("idle_drop_count", 32'(drop_count), 32'd1);

    // Frame start at usedw=3, then pixels 3,4,5 and 6 are real writes.
    step("fs3", 1'b0, 0, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    step("real3", 1'b1, 3, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    step("real4", 1'b1, 4, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    step("real5", 1'b1, 5, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    step("real6", 1'b1, 6, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1);

    // usedw=60 reloads the pointer to 60 mod 50 = 10; rel=15 jumps by 5.
    step("fs60", 1'b0, 0, 60, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    step("jump5", 1'b1, 15, 20, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    check_output("jump5_drop_count", 32'(drop_count), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step("catchup_null", 1'b0, 0, 20, 1'b0, 1'b0, 1'b1, 1'b1, (i == 4) ? 1 : 2);
    end
    check_output("catchup_null_count", 32'(null_count), 32'd8);
    step("real15", 1'b1, 15, 20, 1'b0, 1'b0, 1'b1, 1'b0, 1);

    // Gap of exactly CATCHUP_MAX (16 -> 36) is bridged; a matching read
    // during CATCHUP still wins and returns to STREAM.
    step("jump_max", 1'b1, 36, 20, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    step("match_in_catchup", 1'b1, 16, 20, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    check_output("match_in_catchup_null_count", 32'(null_count), 32'd8);

    // Pointer is 17: gap 21 too far, rel 10 behind, rel 50 out of frame.
    step("too_far", 1'b1, 38, 20, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    check_output("too_far_drop_count", 32'(drop_count), 32'd2);
    step("behind", 1'b1, 10, 20, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    check_output("behind_drop_count", 32'(drop_count), 32'd3);
    step("out_of_frame", 1'b1, 50, 20, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    check_output("out_of_frame_drop_count", 32'(drop_count), 32'd4);

    // Wrap: pointer 49 advances to 0, so rel 0 then matches.
    step("fs49", 1'b0, 0, 49, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    step("real49", 1'b1, 49, 20, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    step("wrap0", 1'b1, 0, 20, 1'b0, 1'b0, 1'b1, 1'b0, 1);

    // FIFO full: matching read lost, low-water null suppressed, pointer holds.
    step("full_match", 1'b1, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    check_output("full_overflow_count", 32'(overflow_count), 32'd1);
    check_output("full_null_count", 32'(null_count), 32'd8);
    step("after_full", 1'b1, 1, 20, 1'b0, 1'b0, 1'b1, 1'b0, 1);

    // Null counter saturates at 15 (8 + 7), then stays there.
    for (int i = 0; i < 7; i++) begin
      step("sat_null", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    end
    check_output("sat_null_count_max", 32'(null_count), 32'd15);
    for (int i = 0; i < 3; i++) begin
      step("sat_hold", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    end
    check_output("sat_null_count_hold", 32'(null_count), 32'd15);

    // Reset asserted in the middle of CATCHUP clears everything at once.
    step("fs20", 1'b0, 0, 20, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    step("jump_pre_reset", 1'b1, 25, 20, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    apply_stimulus(1'b0, 0, 20, 1'b0, 1'b0);
    check_output("pre_reset_wrreq", 32'(wrreq), 32'd1);
    check_output("pre_reset_nullData", 32'(nullData), 32'd1);
    #1;
    portV_arst_n = 1'b0;
    #1;
    check_output("midrst_wrreq", 32'(wrreq), 32'd0);
    check_output("midrst_nullData", 32'(nullData), 32'd0);
    check_output("midrst_state", 32'(state), 32'd0);
    check_output("midrst_null_count", 32'(null_count), 32'd0);
    check_output("midrst_drop_count", 32'(drop_count), 32'd0);
    check_output("midrst_overflow_count", 32'(overflow_count), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
